// File: rtl/roi_pkg.sv
// roi_pkg
// Shared definitions for the ROI row finder: the FSM state type, its
// encoding (also visible on the LEDR debug port) and the default
// parameter values used by the camera top level.
package roi_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEEK    = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SEEK    = ST_SEEK,
    TRACK   = ST_TRACK,
    PUBLISH = ST_PUBLISH
  } roi_state_t;

  localparam int DEF_RUN_LEN  = 128;
  localparam int DEF_Y_MIN    = 50;
  localparam int DEF_Y_MAX    = 910;
  localparam int DEF_MIN_ROWS = 1;

endpackage

// File: rtl/run_detector.sv
// run_detector
// Tracks the current run of consecutive matching pixels within a row and
// raises row_hit once that run has reached RUN_LEN. The hit stays set until
// the next row start, where the counter restarts with the row's first pixel.
//
// Ports:
//   clk       pixel clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of counter and hit (frame start)
//   beat      a valid pixel is present this cycle
//   match     the current pixel has the selected polarity
//   row_start the current beat is column 0 of a new row
//   row_hit   the row seen so far contains a run of at least RUN_LEN
module run_detector
  import roi_pkg::*;
#(
  parameter int X_W     = 16,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic beat,
  input  logic match,
  input  logic row_start,
  output logic row_hit
);

  localparam logic [X_W-1:0] RUN_MAX = X_W'(RUN_LEN);

  logic [X_W-1:0] run_cnt;

  // The counter saturates at RUN_LEN so it can never wrap on long rows.
  // The hit is taken on the same edge the counter reaches RUN_LEN, which is
  // why the row-start pixel alone can hit when RUN_LEN is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      row_hit <= 1'b0;
    end else if (clr) begin
      run_cnt <= '0;
      row_hit <= 1'b0;
    end else if (beat) begin
      if (row_start) begin
        run_cnt <= match ? X_W'(1) : '0;
        row_hit <= (RUN_LEN == 1) && match;
      end else if (match) begin
        if (run_cnt != RUN_MAX)
          run_cnt <= run_cnt + 1'b1;
        if (run_cnt >= RUN_MAX - 1'b1)
          row_hit <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/roi_row_finder.sv
// roi_row_finder
// Scans a binarised pixel stream and, once per frame, reports the band of
// rows (first qualifying top, last qualifying bottom) whose rows contain a
// run of at least RUN_LEN pixels of the selected polarity.
//
// Ports:
//   iCLK        pixel clock (CCD_PIXCLK)
//   iRST_N      asynchronous active-low reset
//   iFVAL       frame valid
//   iDVAL       pixel valid
//   iPIX        binarised pixel, 1 = white
//   iPOL        run polarity, sampled at frame start
//   iX_Cont     column of the current pixel
//   iY_Cont     row of the current pixel
//   oROI_TOP    published top row
//   oROI_BOT    published bottom row
//   oROI_FOUND  last frame produced a band
//   oROI_VALID  one-cycle pulse when results are published
//   oSTATE      FSM state for LEDR debug
module roi_row_finder
  import roi_pkg::*;
#(
  parameter int X_W      = 16,
  parameter int Y_W      = 16,
  parameter int RUN_LEN  = DEF_RUN_LEN,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int MIN_ROWS = DEF_MIN_ROWS
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iFVAL,
  input  logic           iDVAL,
  input  logic           iPIX,
  input  logic           iPOL,
  input  logic [X_W-1:0] iX_Cont,
  input  logic [Y_W-1:0] iY_Cont,
  output logic [Y_W-1:0] oROI_TOP,
  output logic [Y_W-1:0] oROI_BOT,
  output logic           oROI_FOUND,
  output logic           oROI_VALID,
  output logic [1:0]     oSTATE
);

  roi_state_t     state, state_nx;
  logic           fval_d;
  logic           pol;
  logic [Y_W-1:0] row_y;
  logic [Y_W-1:0] cand_top, cand_top_nx;
  logic [Y_W-1:0] bot, bot_nx;
  logic [15:0]    streak, streak_nx;
  logic           band_q, band_nx;
  logic           row_hit;

  logic rise, fall, active, beat, row_start, match, commit, eligible, hit_ok;

  assign rise      = iFVAL & ~fval_d;
  assign fall      = fval_d & ~iFVAL;
  assign active    = (state == SEEK) || (state == TRACK);
  // A row start on the frame-end cycle only commits the old row; the new
  // pixel is dropped by masking the beat.
  assign beat      = iDVAL && active && !fall;
  assign row_start = (iX_Cont == '0);
  assign match     = (iPIX == pol);
  assign commit    = active && (fall || (beat && row_start));
  assign eligible  = (row_y > Y_W'(Y_MIN)) && (row_y < Y_W'(Y_MAX));
  assign hit_ok    = eligible && row_hit;
  assign oSTATE    = state;

  run_detector #(
    .X_W     (X_W),
    .RUN_LEN (RUN_LEN)
  ) u_run (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .clr       ((state == IDLE) && rise),
    .beat      (beat),
    .match     (match),
    .row_start (row_start),
    .row_hit   (row_hit)
  );

  // State register. fval_d resets high so that a reset in the middle of a
  // frame waits for a genuine rising edge instead of seeing one at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      fval_d <= 1'b1;
    end else begin
      state  <= state_nx;
      fval_d <= iFVAL;
    end
  end

  // Next state and band tracking. band_nx remembers whether the frame has
  // reached TRACK, including a transition made by the frame-end commit.
  always_comb begin
    state_nx    = state;
    streak_nx   = streak;
    cand_top_nx = cand_top;
    bot_nx      = bot;
    band_nx     = band_q;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nx    = SEEK;
          streak_nx   = '0;
          cand_top_nx = '0;
          bot_nx      = '0;
          band_nx     = 1'b0;
        end
      end
      SEEK: begin
        if (commit) begin
          if (hit_ok) begin
            if (streak == '0)
              cand_top_nx = row_y;
            streak_nx = streak + 16'd1;
            if ((streak + 16'd1) >= 16'(MIN_ROWS)) begin
              bot_nx   = row_y;
              state_nx = TRACK;
              band_nx  = 1'b1;
            end
          end else begin
            streak_nx = '0;
          end
        end
        if (fall)
          state_nx = PUBLISH;
      end
      TRACK: begin
        if (commit && hit_ok)
          bot_nx = row_y;
        if (fall)
          state_nx = PUBLISH;
      end
      PUBLISH: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Frame-level datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pol      <= 1'b0;
      row_y    <= '0;
      cand_top <= '0;
      bot      <= '0;
      streak   <= '0;
      band_q   <= 1'b0;
    end else begin
      cand_top <= cand_top_nx;
      bot      <= bot_nx;
      streak   <= streak_nx;
      band_q   <= band_nx;
      if ((state == IDLE) && rise)
        pol <= iPOL;
      if (beat && row_start)
        row_y <= iY_Cont;
    end
  end

  // Published results; they hold between publishes.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oROI_TOP   <= '0;
      oROI_BOT   <= '0;
      oROI_FOUND <= 1'b0;
      oROI_VALID <= 1'b0;
    end else begin
      oROI_VALID <= (state == PUBLISH);
      if (state == PUBLISH) begin
        oROI_TOP   <= band_q ? cand_top : '0;
        oROI_BOT   <= band_q ? bot : '0;
        oROI_FOUND <= band_q;
      end
    end
  end

endmodule

// File: tb/tb_roi_row_finder.sv
// tb_roi_row_finder
// Drives frames into two finders (MIN_ROWS 1 and 2) and checks every cycle
// against a frame-level reference that works directly on the pixel arrays.
module tb_roi_row_finder;

  localparam int RL   = 4;
  localparam int YMIN = 2;
  localparam int YMAX = 20;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iFVAL  = 1'b0;
  logic        iDVAL  = 1'b0;
  logic        iPIX   = 1'b0;
  logic        iPOL   = 1'b1;
  logic [15:0] iX_Cont = '0;
  logic [15:0] iY_Cont = '0;

  logic [15:0] top_o   [2];
  logic [15:0] bot_o   [2];
  logic        found_o [2];
  logic        valid_o [2];
  logic [1:0]  st_o    [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit pix [32][16];

  logic [15:0] exp_top [2];
  logic [15:0] exp_bot [2];
  bit          exp_found [2];
  logic [15:0] pend_top [2];
  logic [15:0] pend_bot [2];
  bit          pend_found [2];
  int          due = -1;
  int          vcnt [2];
  bit          ev;
  string       nm [2] = '{"a", "b"};

  roi_row_finder #(.X_W(16), .Y_W(16), .RUN_LEN(RL), .Y_MIN(YMIN), .Y_MAX(YMAX), .MIN_ROWS(1)) dut_a (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iPIX(iPIX), .iPOL(iPOL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oROI_TOP(top_o[0]), .oROI_BOT(bot_o[0]), .oROI_FOUND(found_o[0]),
    .oROI_VALID(valid_o[0]), .oSTATE(st_o[0])
  );

  roi_row_finder #(.X_W(16), .Y_W(16), .RUN_LEN(RL), .Y_MIN(YMIN), .Y_MAX(YMAX), .MIN_ROWS(2)) dut_b (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iPIX(iPIX), .iPOL(iPOL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oROI_TOP(top_o[1]), .oROI_BOT(bot_o[1]), .oROI_FOUND(found_o[1]),
    .oROI_VALID(valid_o[1]), .oSTATE(st_o[1])
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a row qualifies if its longest matching run is at least RL and
  // its y lies strictly inside the window. The band top is the first row
  // that starts mr consecutive qualifying rows; the bottom is the last
  // qualifying row from the end of that group onward.
  function automatic void model(input int nr, input int nc, input bit pol, input int mr,
                                output logic [15:0] t, output logic [15:0] b, output bit f);
    bit q [32];
    for (int r = 0; r < nr; r++) begin
      int run = 0;
      int best = 0;
      for (int c = 0; c < nc; c++) begin
        run = (pix[r][c] == pol) ? run + 1 : 0;
        if (run > best) best = run;
      end
      q[r] = (best >= RL) && (r > YMIN) && (r < YMAX);
    end
    t = '0;
    b = '0;
    f = 1'b0;
    for (int i = 0; (i + mr <= nr) && !f; i++) begin
      bit ok = 1'b1;
      for (int j = 0; j < mr; j++)
        if (!q[i + j]) ok = 1'b0;
      if (ok) begin
        f = 1'b1;
        t = 16'(i);
        b = 16'(i + mr - 1);
        for (int r = i + mr; r < nr; r++)
          if (q[r]) b = 16'(r);
      end
    end
  endfunction

  // Per-cycle comparison of both finders against the held expectations.
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      for (int k = 0; k < 2; k++) begin
        exp_top[k]   = '0;
        exp_bot[k]   = '0;
        exp_found[k] = 1'b0;
      end
    end
    ev = (cyc == due);
    for (int k = 0; k < 2; k++) begin
      if (ev) begin
        exp_top[k]   = pend_top[k];
        exp_bot[k]   = pend_bot[k];
        exp_found[k] = pend_found[k];
      end
      if (valid_o[k] === 1'b1) vcnt[k]++;
      checkOutput({nm[k], ".valid"}, 32'(valid_o[k]), 32'(ev));
      checkOutput({nm[k], ".found"}, 32'(found_o[k]), 32'(exp_found[k]));
      checkOutput({nm[k], ".top"},   32'(top_o[k]),   32'(exp_top[k]));
      checkOutput({nm[k], ".bot"},   32'(bot_o[k]),   32'(exp_bot[k]));
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill(input bit bg);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++)
        pix[r][c] = bg;
  endtask

  task automatic set_row(input int r, input bit v);
    for (int c = 0; c < 16; c++) pix[r][c] = v;
  endtask

  // gap_mode: 0 continuous, 1 DVAL low every other cycle, 2 random gaps.
  // rst_row >= 0 pulses reset at the start of that row; no result expected.
  task automatic applyStimulus(input int nr, input int nc, input bit pol, input int gap_mode, input int rst_row);
    vcnt[0] = 0;
    vcnt[1] = 0;
    iPOL  = pol;
    iFVAL = 1'b1;
    iDVAL = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < nr; r++) begin
      if (r == rst_row) begin
        iRST_N = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          checkOutput({nm[k], ".rst_top"},   32'(top_o[k]),   32'd0);
          checkOutput({nm[k], ".rst_bot"},   32'(bot_o[k]),   32'd0);
          checkOutput({nm[k], ".rst_found"}, 32'(found_o[k]), 32'd0);
          checkOutput({nm[k], ".rst_state"}, 32'(st_o[k]),    32'd0);
        end
        repeat (3) tick();
        iRST_N = 1'b1;
      end
      for (int c = 0; c < nc; c++) begin
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
          iDVAL = 1'b0;
          tick();
        end
        iDVAL   = 1'b1;
        iX_Cont = 16'(c);
        iY_Cont = 16'(r);
        iPIX    = pix[r][c];
        tick();
      end
      iDVAL = 1'b0;
      tick();
      tick();
    end
    iFVAL = 1'b0;
    if (rst_row < 0) begin
      model(nr, nc, pol, 1, pend_top[0], pend_bot[0], pend_found[0]);
      model(nr, nc, pol, 2, pend_top[1], pend_bot[1], pend_found[1]);
      due = cyc + 2;
    end
    repeat (6) tick();
  endtask

  task automatic band_frame(input bit pol);
    fill(!pol);
    for (int r = 5; r <= 8; r++) set_row(r, pol);
  endtask

  initial begin
    fill(1'b0);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput({nm[k], ".reset_valid"}, 32'(valid_o[k]), 32'd0);
      checkOutput({nm[k], ".reset_state"}, 32'(st_o[k]),    32'd0);
    end
    iRST_N = 1'b1;
    repeat (3) tick();

    // Rows 5..8 white.
    band_frame(1'b1);
    applyStimulus(10, 10, 1'b1, 0, -1);
    checkOutput("s1.top", 32'(top_o[0]), 32'd5);
    checkOutput("s1.bot", 32'(bot_o[0]), 32'd8);
    checkOutput("s1.found", 32'(found_o[0]), 32'd1);
    checkOutput("s1.pulses", 32'(vcnt[0]), 32'd1);
    checkOutput("s1.b_top", 32'(top_o[1]), 32'd5);

    // Row 6 only has white runs of 3.
    band_frame(1'b1);
    for (int c = 0; c < 16; c++) pix[6][c] = (c % 4 != 3);
    applyStimulus(10, 10, 1'b1, 0, -1);
    checkOutput("s2.top", 32'(top_o[0]), 32'd5);
    checkOutput("s2.bot", 32'(bot_o[0]), 32'd8);

    // Isolated white rows 5 and 7: no pair for MIN_ROWS=2.
    fill(1'b0);
    set_row(5, 1'b1);
    set_row(7, 1'b1);
    applyStimulus(10, 10, 1'b1, 0, -1);
    checkOutput("s2b.b_found", 32'(found_o[1]), 32'd0);
    checkOutput("s2b.b_top", 32'(top_o[1]), 32'd0);
    checkOutput("s2b.b_bot", 32'(bot_o[1]), 32'd0);
    checkOutput("s2b.a_bot", 32'(bot_o[0]), 32'd7);

    // White rows outside the window only.
    fill(1'b0);
    set_row(1, 1'b1);
    set_row(25, 1'b1);
    applyStimulus(30, 10, 1'b1, 0, -1);
    checkOutput("s3.found", 32'(found_o[0]), 32'd0);

    // DVAL toggling.
    band_frame(1'b1);
    applyStimulus(10, 10, 1'b1, 1, -1);
    checkOutput("s4.top", 32'(top_o[0]), 32'd5);
    checkOutput("s4.bot", 32'(bot_o[0]), 32'd8);

    // Black polarity.
    band_frame(1'b0);
    applyStimulus(10, 10, 1'b0, 0, -1);
    checkOutput("s5.top", 32'(top_o[0]), 32'd5);
    checkOutput("s5.bot", 32'(bot_o[0]), 32'd8);
    checkOutput("s5.found", 32'(found_o[0]), 32'd1);

    // Reset at row 6, then a full frame.
    band_frame(1'b1);
    applyStimulus(10, 10, 1'b1, 0, 6);
    checkOutput("s6.pulses", 32'(vcnt[0]), 32'd0);
    checkOutput("s6.found", 32'(found_o[0]), 32'd0);
    applyStimulus(10, 10, 1'b1, 0, -1);
    checkOutput("s6.top", 32'(top_o[0]), 32'd5);
    checkOutput("s6.bot", 32'(bot_o[0]), 32'd8);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      int nr  = $urandom_range(4, 30);
      int nc  = $urandom_range(4, 16);
      bit pol = 1'($urandom_range(0, 1));
      for (int r = 0; r < 32; r++) begin
        int mode = $urandom_range(0, 3);
        for (int c = 0; c < 16; c++) begin
          case (mode)
            0:       pix[r][c] = pol;
            1:       pix[r][c] = !pol;
            2:       pix[r][c] = 1'($urandom_range(0, 1));
            default: pix[r][c] = ($urandom_range(0, 3) != 0) ? pol : !pol;
          endcase
        end
      end
      applyStimulus(nr, nc, pol, $urandom_range(0, 2), -1);
      checkOutput("rnd.pulses", 32'(vcnt[0]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
